// File: rtl/neuron_loader_pkg.sv
// Shared constants for the neuron parameter loader: FSM encodings,
// header field geometry and config-port width helper.
package neuron_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WEIGHT = 3'd1;
  localparam logic [2:0] ST_BIAS   = 3'd2;
  localparam logic [2:0] ST_FLUSH  = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;

  function automatic int cfg_width(int dw);
    return 2 * dw + 1;
  endfunction

  // Neuron field sits in the low half, layer in the high half.
  function automatic int hdr_neuron_w(int dw);
    return dw / 2;
  endfunction

endpackage

// File: rtl/neuron_param_loader_if.sv
// Valid/ready word stream from the AXI front end into the loader.
// master drives words, slave (the loader) drives s_ready.
interface neuron_param_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/neuron_loader_csum.sv
// Running sum of weights and bias plus compare against the check word.
// Only built when NEURON_LOADER_CHECKSUM_EN is defined.
`ifdef NEURON_LOADER_CHECKSUM_EN
module neuron_loader_csum #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_add,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_match
);

  logic [DATA_WIDTH-1:0] r_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_match = (i_data == r_sum);

endmodule
`endif

// File: rtl/neuron_param_loader.sv
// Header/weights/bias sequencer feeding the shared neuron weight bus.
// Optional trailing checksum word under NEURON_LOADER_CHECKSUM_EN.
module neuron_param_loader
  import neuron_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WEIGHT = 128,
  parameter int NUM_LAYER  = 4,
  parameter int NUM_NEURON = 32
) (
  input  logic clk,
  input  logic rst,
  neuron_param_loader_if.slave s,
  output logic                               weightValid,
  output logic [DATA_WIDTH-1:0]              weightValue,
  output logic                               biasValid,
  output logic [DATA_WIDTH-1:0]              biasValue,
  output logic [cfg_width(DATA_WIDTH)-1:0]   config_layer_num,
  output logic [cfg_width(DATA_WIDTH)-1:0]   config_neuron_num,
  output logic                               done,
  output logic                               err
);

  localparam int CW  = cfg_width(DATA_WIDTH);
  localparam int NBW = hdr_neuron_w(DATA_WIDTH);
  localparam int WCW = $clog2(NUM_WEIGHT + 1);

  logic [2:0]            r_state;
  logic [WCW-1:0]        r_wcnt;
  logic                  r_oor;
  logic                  r_wvalid;
  logic                  r_bvalid;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_wval;
  logic [DATA_WIDTH-1:0] r_bval;
  logic [CW-1:0]         r_layer;
  logic [CW-1:0]         r_neuron;

  logic          w_acc;
  logic          w_wlast;
  logic          w_oor;
  logic [CW-1:0] w_layer;
  logic [CW-1:0] w_neuron;

  // Ready is forced low while reset is held.
  assign s.s_ready = rst & (r_state != ST_FLUSH);
  assign w_acc     = s.s_valid & s.s_ready;
  assign w_wlast   = (r_wcnt == WCW'(NUM_WEIGHT - 1));

  assign w_layer  = CW'(s.s_data[DATA_WIDTH-1:NBW]);
  assign w_neuron = CW'(s.s_data[NBW-1:0]);
  assign w_oor    = (w_layer >= CW'(NUM_LAYER))
                  | (w_neuron >= CW'(NUM_NEURON));

`ifdef NEURON_LOADER_CHECKSUM_EN
  logic w_match;

  neuron_loader_csum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_csum (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_acc & (r_state == ST_IDLE)),
    .i_add   (w_acc & ((r_state == ST_WEIGHT)
                     | (r_state == ST_BIAS))),
    .i_data  (s.s_data),
    .o_match (w_match)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_wcnt   <= '0;
      r_oor    <= 1'b0;
      r_wvalid <= 1'b0;
      r_bvalid <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_wval   <= '0;
      r_bval   <= '0;
      r_layer  <= '0;
      r_neuron <= '0;
    end else begin
      r_wvalid <= 1'b0;
      r_bvalid <= 1'b0;
      r_done   <= 1'b0;
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (w_acc) begin
            r_layer  <= w_layer;
            r_neuron <= w_neuron;
            r_oor    <= w_oor;
            r_err    <= s.s_last | w_oor;
            r_wcnt   <= '0;
            if (!s.s_last) r_state <= ST_WEIGHT;
          end
        end
        (r_state == ST_WEIGHT): begin
          if (w_acc) begin
            r_wvalid <= ~r_oor;
            r_wval   <= s.s_data;
            r_wcnt   <= r_wcnt + WCW'(1);
            // Any s_last here ends the packet before its bias.
            if (s.s_last) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else if (w_wlast) begin
              r_state <= ST_BIAS;
            end
          end
        end
        (r_state == ST_BIAS): begin
          if (w_acc) begin
            r_bvalid <= ~r_oor;
            r_bval   <= s.s_data;
`ifdef NEURON_LOADER_CHECKSUM_EN
            if (s.s_last) r_err <= 1'b1;
            r_state <= s.s_last ? ST_FLUSH : ST_CHECK;
`else
            if (!s.s_last) r_err <= 1'b1;
            r_state <= ST_FLUSH;
`endif
          end
        end
`ifdef NEURON_LOADER_CHECKSUM_EN
        (r_state == ST_CHECK): begin
          if (w_acc) begin
            if (!w_match || !s.s_last) r_err <= 1'b1;
            r_state <= ST_FLUSH;
          end
        end
`endif
        (r_state == ST_FLUSH): begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign weightValid       = r_wvalid;
  assign weightValue       = r_wval;
  assign biasValid         = r_bvalid;
  assign biasValue         = r_bval;
  assign config_layer_num  = r_layer;
  assign config_neuron_num = r_neuron;
  assign done              = r_done;
  assign err               = r_err;

endmodule

// File: tb/tb_neuron_param_loader.sv
// Randomised bench for neuron_param_loader with a packet-level model.
// Honours NEURON_LOADER_CHECKSUM_EN when the design is built with it.
module tb_neuron_param_loader;

  localparam int DW  = 16;
  localparam int NWT = 128;
  localparam int NL  = 4;
  localparam int NN  = 32;
  localparam int CW  = 2 * DW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_param_loader_if #(.DATA_WIDTH(DW)) bus ();

  logic          weightValid, biasValid, done, err;
  logic [DW-1:0] weightValue, biasValue;
  logic [CW-1:0] config_layer_num, config_neuron_num;

  neuron_param_loader #(
    .DATA_WIDTH (DW),
    .NUM_WEIGHT (NWT),
    .NUM_LAYER  (NL),
    .NUM_NEURON (NN)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s                 (bus),
    .weightValid       (weightValid),
    .weightValue       (weightValue),
    .biasValid         (biasValid),
    .biasValue         (biasValue),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .done              (done),
    .err               (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] wq[$];
  logic [DW-1:0] bq[$];
  logic [DW-1:0] w_sent[$];
  logic [CW-1:0] exp_l, exp_n;
  int done_cnt, cfg_bad, spur, cyc, bias_cyc, done_cyc;
  logic r_x = 1'b0;

  always @(posedge clk) r_x <= bus.s_valid & bus.s_ready;

  always @(negedge clk) begin
    cyc++;
    if (weightValid === 1'b1) begin
      wq.push_back(weightValue);
      if (!r_x) spur++;
      if (config_layer_num !== exp_l || config_neuron_num !== exp_n)
        cfg_bad++;
    end
    if (biasValid === 1'b1) begin
      bq.push_back(biasValue);
      bias_cyc = cyc;
      if (!r_x) spur++;
      if (config_layer_num !== exp_l || config_neuron_num !== exp_n)
        cfg_bad++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (config_layer_num !== exp_l || config_neuron_num !== exp_n)
        cfg_bad++;
    end
  end

  task automatic clear_mon();
    wq.delete();
    bq.delete();
    done_cnt = 0;
    cfg_bad  = 0;
    spur     = 0;
    bias_cyc = 0;
    done_cyc = 0;
  endtask

  function automatic bit model_oor(input logic [15:0] hdr);
    return (int'(hdr[15:8]) >= NL) || (int'(hdr[7:0]) >= NN);
  endfunction

  function automatic bit model_err(input logic [15:0] hdr, input int nw,
                                   input bit blast, input bit bad);
    bit e;
    e = model_oor(hdr) || (nw < NWT) || bad;
`ifndef NEURON_LOADER_CHECKSUM_EN
    e = e || !blast;
`endif
    return e;
  endfunction

  task automatic send_word(input logic [DW-1:0] d, input bit last,
                           input int pct);
    bit acc;
    int tries;
    int k;
    k = 0;
    while (k < 20 && $urandom_range(99) < pct) begin
      bus.s_valid = 1'b0;
      @(negedge clk);
      k++;
    end
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      acc = bus.s_ready;
      @(negedge clk);
      tries++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake: word %h s_ready=0 required 1", d);
    end
  endtask

  task automatic send_packet(input logic [15:0] hdr, input bit skip_hdr,
                             input int nw, input bit rnd, input int pct,
                             input logic [DW-1:0] bias, input bit blast,
                             input bit bad);
    logic [DW-1:0] w, sum;
    sum   = '0;
    exp_l = CW'(hdr[15:8]);
    exp_n = CW'(hdr[7:0]);
    w_sent.delete();
    if (!skip_hdr) send_word(hdr, 1'b0, pct);
    for (int i = 0; i < nw; i++) begin
      w = rnd ? DW'($urandom) : DW'(i + 1);
      w_sent.push_back(w);
      sum = sum + w;
      send_word(w, (nw < NWT) && (i == nw - 1), pct);
    end
    if (nw == NWT) begin
      sum = sum + bias;
`ifdef NEURON_LOADER_CHECKSUM_EN
      send_word(bias, 1'b0, pct);
      send_word(sum + (bad ? DW'(1) : DW'(0)), 1'b1, pct);
`else
      send_word(bias, blast, pct);
`endif
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    #1;
    n_cmp++;
    if (bus.s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ready: got %b want 0", bus.s_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({weightValid, weightValue, biasValid, biasValue, config_layer_num,
         config_neuron_num, done, err, bus.s_ready} !== {{(2*DW+2*CW+4){1'b0}}, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_outputs: wv=%b bv=%b done=%b err=%b rdy=%b want 0/0/0/0/1",
               weightValid, biasValid, done, err, bus.s_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int diff;
    clear_mon();
    send_packet(16'h0103, 1'b0, NWT, 1'b0, 0, 16'h0040, 1'b1, 1'b0);
    diff = 0;
    foreach (w_sent[i]) if (i >= wq.size() || wq[i] !== w_sent[i]) diff++;
    n_cmp++;
    if (wq.size() != NWT || diff != 0) begin
      n_bad++;
      $display("FAIL basic_weights: got %0d pulses (%0d wrong) want %0d", wq.size(), diff, NWT);
    end
    n_cmp++;
    if (bq.size() != 1 || bq[0] !== 16'h0040) begin
      n_bad++;
      $display("FAIL basic_bias: got %0d pulses first %h want 1 x 0040", bq.size(), bq.size() ? bq[0] : 16'hx);
    end
    n_cmp++;
    if (config_layer_num !== CW'(1) || config_neuron_num !== CW'(3) || cfg_bad != 0) begin
      n_bad++;
      $display("FAIL basic_cfg: got %0d/%0d bad=%0d want 1/3 bad=0", config_layer_num, config_neuron_num, cfg_bad);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL basic_done: got %0d pulses want 1", done_cnt);
    end
`ifndef NEURON_LOADER_CHECKSUM_EN
    n_cmp++;
    if (done_cyc - bias_cyc != 1) begin
      n_bad++;
      $display("FAIL basic_done_lat: got %0d cycles after bias want 1", done_cyc - bias_cyc);
    end
`endif
    n_cmp++;
    if (err !== model_err(16'h0103, NWT, 1'b1, 1'b0)) begin
      n_bad++;
      $display("FAIL basic_err: got %b want 0", err);
    end
  endtask

  task automatic test_stall();
    int diff;
    clear_mon();
    send_packet(16'h0105, 1'b0, NWT, 1'b1, 50, DW'($urandom), 1'b1, 1'b0);
    diff = 0;
    foreach (w_sent[i]) if (i >= wq.size() || wq[i] !== w_sent[i]) diff++;
    n_cmp++;
    if (wq.size() != NWT || diff != 0) begin
      n_bad++;
      $display("FAIL stall_weights: got %0d pulses (%0d wrong) want %0d", wq.size(), diff, NWT);
    end
    n_cmp++;
    if (spur != 0 || cfg_bad != 0) begin
      n_bad++;
      $display("FAIL stall_spurious: got spur=%0d cfg_bad=%0d want 0/0", spur, cfg_bad);
    end
    n_cmp++;
    if (bq.size() != 1 || done_cnt != 1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_tail: got bias=%0d done=%0d err=%b want 1/1/0", bq.size(), done_cnt, err);
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] hdrs [2];
    hdrs[0] = 16'h0120;
    hdrs[1] = {8'(NL + $urandom_range(3)), 8'($urandom_range(NN - 1))};
    foreach (hdrs[k]) begin
      clear_mon();
      send_packet(hdrs[k], 1'b0, NWT, 1'b1, 20, DW'($urandom), 1'b1, 1'b0);
      n_cmp++;
      if (wq.size() != (model_oor(hdrs[k]) ? 0 : NWT) || bq.size() != 0) begin
        n_bad++;
        $display("FAIL oor_pulses hdr %h: got w=%0d b=%0d want 0/0", hdrs[k], wq.size(), bq.size());
      end
      n_cmp++;
      if (err !== model_err(hdrs[k], NWT, 1'b1, 1'b0) || done_cnt != 1 || bus.s_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL oor_status hdr %h: got err=%b done=%0d rdy=%b want 1/1/1", hdrs[k], err, done_cnt, bus.s_ready);
      end
    end
  endtask

  task automatic test_early_last();
    int diff;
    clear_mon();
    send_packet(16'h0000, 1'b0, 10, 1'b1, 0, '0, 1'b0, 1'b0);
    diff = 0;
    foreach (w_sent[i]) if (i >= wq.size() || wq[i] !== w_sent[i]) diff++;
    n_cmp++;
    if (wq.size() != 10 || diff != 0 || bq.size() != 0) begin
      n_bad++;
      $display("FAIL early_pulses: got w=%0d (%0d wrong) b=%0d want 10/0/0", wq.size(), diff, bq.size());
    end
    n_cmp++;
    if (err !== model_err(16'h0000, 10, 1'b0, 1'b0) || done_cnt != 0 || bus.s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL early_status: got err=%b done=%0d rdy=%b want 1/0/1", err, done_cnt, bus.s_ready);
    end
    clear_mon();
    send_word(16'h0202, 1'b0, 0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL early_err_clear: got %b want 0", err);
    end
    send_packet(16'h0202, 1'b1, NWT, 1'b1, 0, DW'($urandom), 1'b1, 1'b0);
    n_cmp++;
    if (wq.size() != NWT || bq.size() != 1 || err !== 1'b0 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL early_next: got w=%0d b=%0d err=%b done=%0d want %0d/1/0/1", wq.size(), bq.size(), err, done_cnt, NWT);
    end
  endtask

  task automatic test_reset_mid();
    int diff;
    exp_l = CW'(2);
    exp_n = CW'(7);
    send_word(16'h0207, 1'b0, 0);
    for (int i = 0; i < 60; i++) send_word(DW'($urandom), 1'b0, 0);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({weightValid, weightValue, biasValid, biasValue, config_layer_num,
         config_neuron_num, done, err, bus.s_ready} !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs: wv=%b bv=%b cfg=%0d/%0d done=%b err=%b rdy=%b want all 0",
               weightValid, biasValid, config_layer_num, config_neuron_num, done, err, bus.s_ready);
    end
    clear_mon();
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h1234;
    repeat (3) @(negedge clk);
    bus.s_valid = 1'b0;
    n_cmp++;
    if (wq.size() != 0 || bq.size() != 0 || done_cnt != 0) begin
      n_bad++;
      $display("FAIL midrst_quiet: got w=%0d b=%0d done=%0d want 0/0/0", wq.size(), bq.size(), done_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    clear_mon();
    send_packet(16'h0302, 1'b0, NWT, 1'b1, 30, DW'($urandom), 1'b1, 1'b0);
    diff = 0;
    foreach (w_sent[i]) if (i >= wq.size() || wq[i] !== w_sent[i]) diff++;
    n_cmp++;
    if (wq.size() != NWT || diff != 0 || bq.size() != 1 || err !== 1'b0 || cfg_bad != 0) begin
      n_bad++;
      $display("FAIL midrst_reload: got w=%0d (%0d wrong) b=%0d err=%b cfg_bad=%0d want %0d/0/1/0/0",
               wq.size(), diff, bq.size(), err, cfg_bad, NWT);
    end
  endtask

`ifdef NEURON_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_mon();
    send_packet(16'h0011, 1'b0, NWT, 1'b1, 10, DW'($urandom), 1'b1, 1'b0);
    n_cmp++;
    if (err !== model_err(16'h0011, NWT, 1'b1, 1'b0) || done_cnt != 1) begin
      n_bad++;
      $display("FAIL csum_good: got err=%b done=%0d want 0/1", err, done_cnt);
    end
    clear_mon();
    send_packet(16'h0012, 1'b0, NWT, 1'b1, 10, DW'($urandom), 1'b1, 1'b1);
    n_cmp++;
    if (err !== model_err(16'h0012, NWT, 1'b1, 1'b1) || done_cnt != 1) begin
      n_bad++;
      $display("FAIL csum_bad: got err=%b done=%0d want 1/1", err, done_cnt);
    end
  endtask
`else
  task automatic test_bias_no_last();
    clear_mon();
    send_packet(16'h0304, 1'b0, NWT, 1'b1, 10, DW'($urandom), 1'b0, 1'b0);
    n_cmp++;
    if (err !== model_err(16'h0304, NWT, 1'b0, 1'b0) || done_cnt != 1 || bq.size() != 1) begin
      n_bad++;
      $display("FAIL bias_nolast: got err=%b done=%0d b=%0d want 1/1/1", err, done_cnt, bq.size());
    end
  endtask
`endif

  initial begin
    exp_l = '0;
    exp_n = '0;
    cyc   = 0;
    clear_mon();
    test_reset();
    test_basic();
    test_stall();
    test_out_of_range();
    test_early_last();
    test_reset_mid();
`ifdef NEURON_LOADER_CHECKSUM_EN
    test_checksum();
`else
    test_bias_no_last();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
